// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          WORD_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Memory-side, redirect and decoder-side signals of the fetch stage.
interface instr_fetch_if;
    import fetch_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [WORD_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;
    logic              instr_valid;
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instruction, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instruction, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO; flush is applied after pop and wins over push.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       wdata,
    input  logic                   pop,
    input  logic                   flush,
    output T                       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    T             mem_q [DEPTH];
    T             mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next pointers, occupancy and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // FIFO state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: credit-limited in-order requests, redirect with stale-response
// discard, and a prefetch FIFO presenting {pc, word} to the decoder.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    instr_fetch_if.master  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              run_q, run_d;
    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic [CW-1:0]     fifo_count;
    logic [CW:0]       in_use;
    logic              credit_ok, grant, redirect, rvalid, rsp_keep;
    logic              fifo_empty, fifo_full_unused;
    fetch_entry_t      fifo_head;
    logic [WORD_W-1:0] tag_head;
    logic              tag_full_unused, tag_empty_unused;
    logic [CW-1:0]     tag_count_unused;
    logic [1:0]        redirect_lsb_unused;

    assign redirect            = bus.redirect_valid;
    assign rvalid              = bus.imem_rvalid;
    assign redirect_lsb_unused = bus.redirect_pc[1:0];

    // FIFO entries plus in-flight requests may never exceed the FIFO depth,
    // so every granted response always has a slot waiting for it.
    assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign credit_ok = (in_use < (CW+1)'(FIFO_DEPTH));
    assign grant     = bus.imem_req & bus.imem_gnt;
    assign rsp_keep  = rvalid & (discard_q == '0) & ~redirect;

    assign bus.imem_req    = run_q & ~redirect & credit_ok;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = ~fifo_empty;
    assign bus.instruction = fifo_empty ? '0 : fifo_head.word;
    assign bus.instr_pc    = fifo_empty ? '0 : fifo_head.pc;

    // Next fetch address, credit and discard bookkeeping.
    always_comb begin
        run_d         = 1'b1;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(rvalid);
        discard_d     = discard_q;
        if (redirect) begin
            fetch_pc_d = {bus.redirect_pc[WORD_W-1:2], 2'b00};
            discard_d  = outstanding_q - CW'(rvalid);
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + PC_INC;
            if (rvalid && discard_q != '0) discard_d = discard_q - CW'(1);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            run_q         <= run_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Address of each live request, consumed as its response returns.
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [WORD_W-1:0])) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant),
        .wdata (fetch_pc_q),
        .pop   (rvalid & (discard_q == '0)),
        .flush (redirect),
        .rdata (tag_head),
        .full  (tag_full_unused),
        .empty (tag_empty_unused),
        .count (tag_count_unused)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_entry_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_keep),
        .wdata ('{pc: tag_head, word: bus.imem_rdata}),
        .pop   (bus.instr_valid & bus.instr_ready),
        .flush (redirect),
        .rdata (fifo_head),
        .full  (fifo_full_unused),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
